// File: rtl/semaforo_pkg.sv
// Shared state encoding and lamp decode for the two-road intersection controller.
package semaforo_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        MAIN_GRN = 3'd0,
        MAIN_YLW = 3'd1,
        ALL_RED1 = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YLW = 3'd4,
        ALL_RED2 = 3'd5,
        FLASH    = 3'd6
    } state_t;

    // Bit order: {main_red, main_ylw, main_grn, side_red, side_ylw, side_grn, ped_walk}
    function automatic logic [6:0] lamp_decode(state_t s, logic flash_phase);
        logic [6:0] l;
        unique case (s)
            MAIN_GRN: l = 7'b0011000;
            MAIN_YLW: l = 7'b0101000;
            ALL_RED1: l = 7'b1001000;
            SIDE_GRN: l = 7'b1000011;
            SIDE_YLW: l = 7'b1000100;
            ALL_RED2: l = 7'b1001000;
            FLASH:    l = {1'b0, flash_phase, 2'b00, flash_phase, 2'b00};
            default:  l = 7'b1001000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Phase timer: saturating up-counter with synchronous clear.
module semaforo_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (count_q != '1)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/semaforo_cruzamento_param.sv
// Two-road intersection controller: main/side phases, all-red clearance,
// latched pedestrian request and flashing-yellow maintenance mode.
module semaforo_cruzamento_param
    import semaforo_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned T_GRN_MIN  = 20,
    parameter int unsigned T_YLW      = 4,
    parameter int unsigned T_RED_ALL  = 2,
    parameter int unsigned T_SIDE_GRN = 12,
    parameter int unsigned T_FLASH    = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CAR,
    input  logic       PED,
    input  logic       flash_en,
    output logic       main_red,
    output logic       main_ylw,
    output logic       main_grn,
    output logic       side_red,
    output logic       side_ylw,
    output logic       side_grn,
    output logic       ped_walk,
    output logic [2:0] state_out
);

    localparam int unsigned MAX_T = (1 << CNT_W) - 1;

    generate
        if (T_GRN_MIN == 0 || T_GRN_MIN > MAX_T ||
            T_YLW == 0 || T_YLW > MAX_T ||
            T_RED_ALL == 0 || T_RED_ALL > MAX_T ||
            T_SIDE_GRN == 0 || T_SIDE_GRN > MAX_T ||
            T_FLASH == 0 || T_FLASH > MAX_T) begin : g_bad_duration
            $error("semaforo_cruzamento_param: every duration must lie in 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] GRN_LAST  = CNT_W'(T_GRN_MIN - 1);
    localparam logic [CNT_W-1:0] YLW_LAST  = CNT_W'(T_YLW - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(T_RED_ALL - 1);
    localparam logic [CNT_W-1:0] SIDE_LAST = CNT_W'(T_SIDE_GRN - 1);
    localparam logic [CNT_W-1:0] FLS_LAST  = CNT_W'(T_FLASH - 1);

    state_t           state_q, state_d;
    logic             ped_q, ped_d;
    logic             fp_q, fp_d;
    logic             flash_tick;
    logic             timer_clr;
    logic [CNT_W-1:0] timer;
    logic [6:0]       lamps_q;

    semaforo_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .clr_i   (timer_clr),
        .count_o (timer)
    );

    always_comb begin
        state_d = state_q;
        if (flash_en) begin
            state_d = FLASH;
        end else begin
            unique case (state_q)
                MAIN_GRN: if (timer >= GRN_LAST && (CAR || ped_q)) state_d = MAIN_YLW;
                MAIN_YLW: if (timer == YLW_LAST)  state_d = ALL_RED1;
                ALL_RED1: if (timer == RED_LAST)  state_d = SIDE_GRN;
                SIDE_GRN: if (timer == SIDE_LAST) state_d = SIDE_YLW;
                SIDE_YLW: if (timer == YLW_LAST)  state_d = ALL_RED2;
                ALL_RED2: if (timer == RED_LAST)  state_d = MAIN_GRN;
                FLASH:    state_d = ALL_RED2;
                default:  state_d = MAIN_GRN;
            endcase
        end

        flash_tick = (state_q == FLASH) && flash_en && (timer == FLS_LAST);
        // The timer restarts on a state change and on each flash half-period.
        timer_clr  = (state_d != state_q) || flash_tick;

        fp_d = fp_q;
        if (state_d == FLASH && state_q != FLASH)
            fp_d = 1'b1;
        else if (flash_tick)
            fp_d = ~fp_q;

        ped_d = ped_q;
        if (state_d == SIDE_GRN && state_q != SIDE_GRN)
            ped_d = 1'b0;
        else if (state_q == FLASH)
            ped_d = 1'b0;
        else if (PED && state_q != SIDE_GRN)
            ped_d = 1'b1;
    end

    // Lamps are registered from the next state so they switch on the same edge as state_q.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= MAIN_GRN;
            ped_q   <= 1'b0;
            fp_q    <= 1'b0;
            lamps_q <= lamp_decode(MAIN_GRN, 1'b0);
        end else begin
            state_q <= state_d;
            ped_q   <= ped_d;
            fp_q    <= fp_d;
            lamps_q <= lamp_decode(state_d, fp_d);
        end
    end

    assign {main_red, main_ylw, main_grn, side_red, side_ylw, side_grn, ped_walk} = lamps_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_semaforo_cruzamento_param.sv
// Self-checking bench: directed scenarios plus randomized traffic against a phase-table model.
module tb_semaforo_cruzamento_param;

    localparam int CNT_W      = 4;
    localparam int T_GRN_MIN  = 4;
    localparam int T_YLW      = 2;
    localparam int T_RED_ALL  = 1;
    localparam int T_SIDE_GRN = 3;
    localparam int T_FLASH    = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       CAR = 1'b0, PED = 1'b0, flash_en = 1'b0;
    logic       main_red, main_ylw, main_grn, side_red, side_ylw, side_grn, ped_walk;
    logic [2:0] state_out;

    int checks = 0;
    int failures = 0;

    // Model: phase index 0..5 around the cycle, 6 = flashing; elapsed cycles in the phase.
    int m_phase = 0;
    int m_el = 0;
    bit m_ped = 0;
    bit m_fp = 0;
    bit m_valid = 0;
    int dur[6] = '{T_GRN_MIN, T_YLW, T_RED_ALL, T_SIDE_GRN, T_YLW, T_RED_ALL};

    semaforo_cruzamento_param #(
        .CNT_W(CNT_W), .T_GRN_MIN(T_GRN_MIN), .T_YLW(T_YLW),
        .T_RED_ALL(T_RED_ALL), .T_SIDE_GRN(T_SIDE_GRN), .T_FLASH(T_FLASH)
    ) dut (
        .Clock(Clock), .Reset(Reset), .CAR(CAR), .PED(PED), .flash_en(flash_en),
        .main_red(main_red), .main_ylw(main_ylw), .main_grn(main_grn),
        .side_red(side_red), .side_ylw(side_ylw), .side_grn(side_grn),
        .ped_walk(ped_walk), .state_out(state_out)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lamps(input int ph, input bit fp);
        case (ph)
            0: return 7'b0011000;
            1: return 7'b0101000;
            2: return 7'b1001000;
            3: return 7'b1000011;
            4: return 7'b1000100;
            5: return 7'b1001000;
            default: return {1'b0, fp, 2'b00, fp, 2'b00};
        endcase
    endfunction

    task automatic model_step();
        int p0;
        p0 = m_phase;
        if (Reset) begin
            m_phase = 0; m_el = 0; m_ped = 0; m_fp = 0; m_valid = 1;
            return;
        end
        if (flash_en) begin
            if (p0 != 6) begin
                m_phase = 6; m_el = 0; m_fp = 1;
            end else begin
                m_el++;
                if (m_el == T_FLASH) begin m_fp = !m_fp; m_el = 0; end
            end
        end else if (p0 == 6) begin
            m_phase = 5; m_el = 0;
        end else if (p0 == 0) begin
            if (m_el + 1 >= T_GRN_MIN && (CAR || m_ped)) begin m_phase = 1; m_el = 0; end
            else m_el++;
        end else begin
            m_el++;
            if (m_el == dur[p0]) begin m_phase = (p0 + 1) % 6; m_el = 0; end
        end
        if (m_phase == 3 && p0 != 3) m_ped = 0;
        else if (p0 == 6)            m_ped = 0;
        else if (PED && p0 != 3)     m_ped = 1;
    endtask

    task automatic compare_all();
        chk("state", int'(state_out), m_phase);
        chk("lamps", int'({main_red, main_ylw, main_grn, side_red, side_ylw, side_grn, ped_walk}),
            exp_lamps(m_phase, m_fp));
        chk("invariant", int'((main_grn && main_ylw) || (side_grn && side_ylw) ||
            (main_ylw && side_ylw && state_out != 3'd6)), 0);
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_step();
        #1;
        if (m_valid) compare_all();
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) cycle();
        Reset = 1'b0;
    endtask

    task automatic wait_state(input int code, input string name);
        int n;
        n = 0;
        while (int'(state_out) != code && n < 40) begin cycle(); n++; end
        chk(name, int'(state_out), code);
    endtask

    int seq2[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    int fseq[6]  = '{1, 1, 0, 0, 1, 1};

    initial begin
        int walks;

        // Idle with no demand: main green forever
        do_reset(2);
        chk("rst_state", int'(state_out), 0);
        chk("rst_lamps", int'({main_red, main_ylw, main_grn, side_red, side_ylw, side_grn, ped_walk}),
            7'b0011000);
        repeat (30) cycle();
        chk("idle_state", int'(state_out), 0);

        // CAR held: full 13-cycle rotation
        CAR = 1'b1;
        do_reset(2);
        chk("seq2_0", int'(state_out), seq2[0]);
        for (int i = 1; i < 14; i++) begin
            cycle();
            chk("seq2", int'(state_out), seq2[i]);
        end
        CAR = 1'b0;
        repeat (15) cycle();

        // Single PED pulse after minimum green
        do_reset(2);
        repeat (9) cycle();
        PED = 1'b1;
        cycle();
        PED = 1'b0;
        chk("ped_edge", int'(state_out), 0);
        cycle();
        chk("ped_ylw", int'(state_out), 1);
        walks = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (ped_walk) walks++;
        end
        chk("ped_walks", walks, 3);
        chk("ped_cleared", int'(state_out), 0);

        // PED at SIDE_GRN entry and during SIDE_GRN is not latched
        do_reset(1);
        CAR = 1'b1;
        wait_state(1, "wait_ylw4");
        CAR = 1'b0;
        wait_state(2, "wait_red4");
        PED = 1'b1;
        cycle();
        chk("entry_side", int'(state_out), 3);
        repeat (2) cycle();
        PED = 1'b0;
        repeat (30) cycle();
        chk("no_latch", int'(state_out), 0);

        // Flash during SIDE_GRN
        do_reset(1);
        CAR = 1'b1;
        wait_state(3, "wait_side5");
        CAR = 1'b0;
        flash_en = 1'b1;
        cycle();
        chk("flash_enter", int'(state_out), 6);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cycle();
            chk("flash_mylw", int'(main_ylw), fseq[i]);
            chk("flash_sylw", int'(side_ylw), fseq[i]);
        end
        flash_en = 1'b0;
        cycle();
        chk("flash_exit", int'(state_out), 5);
        cycle();
        chk("flash_main", int'(state_out), 0);

        // Reset mid-MAIN_YLW restarts a full minimum green
        CAR = 1'b1;
        wait_state(1, "wait_ylw6");
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("rst_ylw", int'(state_out), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_timer0", int'(state_out), 0);
        end
        cycle();
        chk("rst_timer_end", int'(state_out), 1);

        // Reset mid-FLASH wins over flash_en
        CAR = 1'b0;
        flash_en = 1'b1;
        repeat (3) cycle();
        Reset = 1'b1;
        flash_en = 1'b0;
        cycle();
        Reset = 1'b0;
        chk("rst_flash", int'(state_out), 0);

        // Reset clears a pending pedestrian request
        PED = 1'b1;
        cycle();
        PED = 1'b0;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        repeat (30) cycle();
        chk("rst_ped", int'(state_out), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            CAR = ($urandom % 4) == 0;
            PED = ($urandom % 16) == 0;
            if (($urandom % 64) == 0) flash_en = !flash_en;
            Reset = ($urandom % 200) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
